// File: rtl/intra_nb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : intra_nb_ram_arb
// Purpose  : Arbiter and sequencer for the single-port intra neighbour
//            line-buffer RAM (4096 x 32). It serves one posted write
//            requester, which is the reconstructed bottom-row writeback,
//            through a small write FIFO. It also serves two read requesters:
//            port 0 is the intra neighbour fetch and port 1 is the deblocking
//            top-row fetch. Reads are granted combinationally with
//            round-robin between the two ports. A buffered write that is
//            deferred too long is forced out to the RAM.
// Ports    : clk, reset_n (asynchronous, active-low)
//            wr_req/wr_addr/wr_data/wr_ready       - posted write push
//            rd_reqN/rd_addrN/rd_gntN/rd_validN    - read ports 0 and 1
//            rd_data                               - shared read return
//            ram_rd_n/ram_wr_n/ram_addr/ram_din    - RAM strobes, address, data
//            ram_dout                              - RAM read data (T+1)
//            wfifo_empty                           - no writes buffered
// Options  : NB_ARB_FWD_EN - a read that hits a buffered write is served from
//            the youngest matching FIFO entry. Without it, such a read stalls
//            until every matching entry has drained.
// Revision : 1.0 - initial release
// ============================================================================
module intra_nb_ram_arb #(
    parameter int WFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_req,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        rd_req0,
    input  logic [11:0] rd_addr0,
    input  logic        rd_req1,
    input  logic [11:0] rd_addr1,
    output logic        rd_gnt0,
    output logic        rd_gnt1,
    output logic        rd_valid0,
    output logic        rd_valid1,
    output logic [31:0] rd_data,
    output logic        ram_rd_n,
    output logic        ram_wr_n,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic        wfifo_empty
);
    localparam int c_PTR_W = $clog2(WFIFO_DEPTH);
    localparam int c_CNT_W = $clog2(WFIFO_DEPTH + 1);
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_FULL       = c_CNT_W'(WFIFO_DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_MAX);

    logic [11:0]            r_fifo_addr [WFIFO_DEPTH];
    logic [31:0]            r_fifo_data [WFIFO_DEPTH];
    logic [WFIFO_DEPTH-1:0] r_vld;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_STV_W-1:0]     r_starve;
    logic                   r_last;     // last port granted (1 after reset)
    logic                   r_valid0;
    logic                   r_valid1;

    logic                   w_empty;
    logic                   w_force;
    logic                   w_push;
    logic                   w_haz0;
    logic                   w_haz1;
    logic                   w_elig0;
    logic                   w_elig1;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_gnt_fifo;
    logic                   w_ram_rd;
    logic                   w_drain;
    logic [WFIFO_DEPTH-1:0] w_hit0;
    logic [WFIFO_DEPTH-1:0] w_hit1;
    logic [WFIFO_DEPTH-1:0] w_vld_nxt;

    assign w_empty     = (r_count == '0);
    assign w_force     = (r_count == c_FULL) || (r_starve == c_STARVE_MAX);
    assign wr_ready    = (r_count != c_FULL);
    assign wfifo_empty = w_empty;
    assign w_push      = wr_req && wr_ready;

    // A read hits the FIFO when its address matches any occupied slot.
    for (genvar gi = 0; gi < WFIFO_DEPTH; gi++) begin : g_hazard
        assign w_hit0[gi] = r_vld[gi] && (r_fifo_addr[gi] == rd_addr0);
        assign w_hit1[gi] = r_vld[gi] && (r_fifo_addr[gi] == rd_addr1);
    end
    assign w_haz0 = |w_hit0;
    assign w_haz1 = |w_hit1;

`ifdef NB_ARB_FWD_EN
    // Hazarded reads are served from the FIFO, so they remain eligible even
    // while a forced drain owns the RAM.
    assign w_elig0    = reset_n && rd_req0 && (!w_force || w_haz0);
    assign w_elig1    = reset_n && rd_req1 && (!w_force || w_haz1);
    assign w_gnt_fifo = (w_gnt0 && w_haz0) || (w_gnt1 && w_haz1);
`else
    assign w_elig0    = reset_n && rd_req0 && !w_haz0 && !w_force;
    assign w_elig1    = reset_n && rd_req1 && !w_haz1 && !w_force;
    assign w_gnt_fifo = 1'b0;
`endif

    // On a tie, the port that was not granted last wins.
    assign w_gnt0   = w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1   = w_elig1 && !w_gnt0;
    assign w_ram_rd = (w_gnt0 || w_gnt1) && !w_gnt_fifo;
    // The RAM slot goes to the FIFO head whenever a RAM read does not use it.
    // This covers forced drains, idle reads and forwarded reads.
    assign w_drain  = !w_empty && !w_ram_rd;

    assign rd_gnt0  = w_gnt0;
    assign rd_gnt1  = w_gnt1;
    assign ram_rd_n = !w_ram_rd;
    assign ram_wr_n = !w_drain;
    assign ram_addr = w_drain  ? r_fifo_addr[r_rd_ptr] :
                      w_ram_rd ? (w_gnt0 ? rd_addr0 : rd_addr1) : 12'h000;
    assign ram_din  = w_drain ? r_fifo_data[r_rd_ptr] : 32'h0000_0000;

    always_comb begin
        w_vld_nxt = r_vld;
        if (w_drain) w_vld_nxt[r_rd_ptr] = 1'b0;
        if (w_push)  w_vld_nxt[r_wr_ptr] = 1'b1;
    end

    // Write FIFO storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_starve <= '0;
            r_last   <= 1'b1;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_drain) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_vld   <= w_vld_nxt;
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_drain);
            if (w_drain || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + c_STV_W'(1);
            end
            if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
            r_valid0 <= w_gnt0;
            r_valid1 <= w_gnt1;
        end
    end

    assign rd_valid0 = r_valid0;
    assign rd_valid1 = r_valid1;

`ifdef NB_ARB_FWD_EN
    logic [31:0] w_fwd_data0;
    logic [31:0] w_fwd_data1;
    logic [31:0] r_fwd_data;
    logic        r_fwd_sel;

    // Walk the FIFO from oldest to youngest so the youngest match wins.
    always_comb begin : p_fwd
        logic [c_PTR_W-1:0] v_idx;
        v_idx       = '0;
        w_fwd_data0 = '0;
        w_fwd_data1 = '0;
        for (int k = 0; k < WFIFO_DEPTH; k++) begin
            v_idx = r_rd_ptr + c_PTR_W'(k);
            if (w_hit0[v_idx]) w_fwd_data0 = r_fifo_data[v_idx];
            if (w_hit1[v_idx]) w_fwd_data1 = r_fifo_data[v_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_sel  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_sel <= w_gnt_fifo;
            if (w_gnt_fifo) r_fwd_data <= w_gnt0 ? w_fwd_data0 : w_fwd_data1;
        end
    end

    assign rd_data = !(r_valid0 || r_valid1) ? 32'h0000_0000 :
                     r_fwd_sel ? r_fwd_data : ram_dout;
`else
    assign rd_data = (r_valid0 || r_valid1) ? ram_dout : 32'h0000_0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_intra_nb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_intra_nb_ram_arb
// Purpose  : Self-checking bench for intra_nb_ram_arb. It contains a RAM
//            model and a queue-based reference model of the write FIFO and
//            the arbitration rules. Directed scenarios are followed by
//            randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intra_nb_ram_arb;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_req0, rd_req1;
    logic [11:0] rd_addr0, rd_addr1;
    logic        rd_gnt0, rd_gnt1, rd_valid0, rd_valid1;
    logic [31:0] rd_data;
    logic        ram_rd_n, ram_wr_n;
    logic [11:0] ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        wfifo_empty;

    always #5 clk = ~clk;

    intra_nb_ram_arb #(.WFIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req0(rd_req0), .rd_addr0(rd_addr0), .rd_req1(rd_req1), .rd_addr1(rd_addr1),
        .rd_gnt0(rd_gnt0), .rd_gnt1(rd_gnt1), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
        .rd_data(rd_data), .ram_rd_n(ram_rd_n), .ram_wr_n(ram_wr_n), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .wfifo_empty(wfifo_empty)
    );

    typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_t;

    wr_t         mq[$];          // writes accepted but not yet in the RAM
    logic [31:0] mem  [4096];    // RAM contents
    logic [31:0] arch [4096];    // value each address must read back
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    bit          m_last;         // last granted port
    int          m_starve;       // cycles the buffered head has been deferred
    bit          exp_v0, exp_v1;
    logic [31:0] exp_data;
    bit          s_gnt0, s_gnt1, s_drain, s_ready, s_v0, s_v1;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are already driven. Check the DUT against the
    // model, advance the model, then clock the RAM model.
    task automatic tick();
        bit haz0, haz1, forced, el0, el1, g0, g1, hz_g, ram_rd, drain, push;
        bit rd_now, wr_now;
        logic [11:0] gaddr, a_now;
        logic [31:0] d_now;
        int sz;
        #1;
        sz = mq.size();
        check("rd_valid0", rd_valid0, exp_v0);
        check("rd_valid1", rd_valid1, exp_v1);
        if (exp_v0 || exp_v1) check("rd_data", rd_data, exp_data);
        check("wr_ready", wr_ready, sz != DEPTH);
        check("wfifo_empty", wfifo_empty, sz == 0);
        haz0 = 1'b0;
        haz1 = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].a == rd_addr0) haz0 = 1'b1;
            if (mq[i].a == rd_addr1) haz1 = 1'b1;
        end
        forced = (sz == DEPTH) || (m_starve == SMAX);
`ifdef NB_ARB_FWD_EN
        el0 = rd_req0 && (!forced || haz0);
        el1 = rd_req1 && (!forced || haz1);
`else
        el0 = rd_req0 && !haz0 && !forced;
        el1 = rd_req1 && !haz1 && !forced;
`endif
        g0     = el0 && (!el1 || m_last);
        g1     = el1 && !g0;
        hz_g   = (g0 && haz0) || (g1 && haz1);
        ram_rd = (g0 || g1) && !hz_g;
        drain  = (sz != 0) && !ram_rd;
        gaddr  = g0 ? rd_addr0 : rd_addr1;
        check("rd_gnt0", rd_gnt0, g0);
        check("rd_gnt1", rd_gnt1, g1);
        check("ram_rd_n", ram_rd_n, !ram_rd);
        check("ram_wr_n", ram_wr_n, !drain);
        check("ram_addr", ram_addr, drain ? mq[0].a : (ram_rd ? gaddr : 12'h000));
        check("ram_din", ram_din, drain ? mq[0].d : 32'h0);
        s_gnt0  = rd_gnt0;
        s_gnt1  = rd_gnt1;
        s_drain = !ram_wr_n;
        s_ready = wr_ready;
        s_v0    = rd_valid0;
        s_v1    = rd_valid1;
        rd_now  = !ram_rd_n;
        wr_now  = !ram_wr_n;
        a_now   = ram_addr;
        d_now   = ram_din;
        // advance the model
        exp_v0 = g0;
        exp_v1 = g1;
        if (g0 || g1) begin
            exp_data = arch[gaddr];
            m_last   = g1;
        end
        push = wr_req && (sz != DEPTH);
        if (drain || sz == 0) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (drain) void'(mq.pop_front());
        if (push) begin
            mq.push_back('{a: wr_addr, d: wr_data});
            arch[wr_addr] = wr_data;
        end
        @(posedge clk);
        if (wr_now) mem[a_now] = d_now;
        if (rd_now) ram_dout = mem[a_now];
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_last   = 1'b1;
        m_starve = 0;
        exp_v0   = 1'b0;
        exp_v1   = 1'b0;
        exp_data = '0;
        for (int i = 0; i < 4096; i++) arch[i] = mem[i];
    endtask

    initial begin
        int k, w, n, g;
        bit saw_full, saw_drain, f_gnt;
        reset_n = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req0 = 1'b0; rd_addr0 = '0; rd_req1 = 1'b0; rd_addr1 = '0;
        ram_dout = '0;
        s_gnt0 = 1'b0; s_gnt1 = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
        model_reset();

        // reset values
        @(negedge clk); #1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_wfifo_empty", wfifo_empty, 1);
        check("rst_ram_rd_n", ram_rd_n, 1);
        check("rst_ram_wr_n", ram_wr_n, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_rd_valid", {rd_valid1, rd_valid0}, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // both ports requesting: grants alternate starting with port 0
        rd_req0 = 1'b1; rd_addr0 = 12'h010; rd_req1 = 1'b1; rd_addr1 = 12'h020;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_gnt0", s_gnt0, (i % 2) == 0);
            check("alt_gnt1", s_gnt1, (i % 2) == 1);
        end
        rd_req0 = 1'b0; rd_req1 = 1'b0;
        tick();

        // single port-0 read of 0x123
        rd_req0 = 1'b1; rd_addr0 = 12'h123;
        tick();
        check("single_gnt0", s_gnt0, 1);
        rd_req0 = 1'b0;
        #1;
        check("single_valid0", rd_valid0, 1);
        check("single_data", rd_data, init_val(12'h123));
        tick();

        // five back-to-back writes while both ports saturate the RAM
        rd_req0 = 1'b1; rd_addr0 = 12'h800; rd_req1 = 1'b1; rd_addr1 = 12'h801;
        wr_req = 1'b1;
        k = 0; g = 0; saw_full = 1'b0; saw_drain = 1'b0;
        while (k < 5 && g < 20) begin
            wr_addr = 12'h100 + 12'(k);
            wr_data = 32'hC0DE_0000 + 32'(k);
            tick();
            if (s_drain) saw_drain = 1'b1;
            if (!s_ready) saw_full = 1'b1;
            else k++;
            g++;
        end
        wr_req = 1'b0;
        check("five_pushed", k, 5);
        check("five_ready_dropped", saw_full, 1);
        check("five_forced_drain", saw_drain, 1);
        for (g = 0; g < 80; g++) begin
            if (wfifo_empty) break;
            tick();
        end
        check("five_drained", wfifo_empty, 1);
        for (int i = 0; i < 5; i++) check("five_ram", mem[12'h100 + i], 32'hC0DE_0000 + 32'(i));
        rd_req0 = 1'b0; rd_req1 = 1'b0;
        tick();

        // read-after-write on port 1
        wr_req = 1'b1; wr_addr = 12'h040; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_req = 1'b0;
        rd_req1 = 1'b1; rd_addr1 = 12'h040;
        w = 0;
        while (w < 10) begin
            tick();
            if (s_gnt1) break;
            w++;
        end
`ifdef NB_ARB_FWD_EN
        check("raw_stall_cycles", w, 0);
`else
        check("raw_stall_cycles", w, 1);
`endif
        rd_req1 = 1'b0;
        #1;
        check("raw_valid1", rd_valid1, 1);
        check("raw_data", rd_data, 32'hDEAD_BEEF);
        tick();

        // starvation bound: one buffered write, port 0 always requesting
        rd_req0 = 1'b1; rd_addr0 = 12'h200;
        wr_req = 1'b1; wr_addr = 12'h300; wr_data = 32'h5555_AAAA;
        tick();
        wr_req = 1'b0;
        n = 0; f_gnt = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (s_drain && n == 0) begin
                n = c;
                f_gnt = s_gnt0;
            end
        end
        check("starve_force_cycle", n, 9);
        check("starve_no_gnt", f_gnt, 0);

        // reset with three writes buffered
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; wr_addr = 12'h310 + 12'(i); wr_data = 32'h7700_0000 + 32'(i);
            tick();
        end
        wr_req = 1'b0;
        check("prerst_buffered", wfifo_empty, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_wfifo_empty", wfifo_empty, 1);
        check("midrst_wr_ready", wr_ready, 1);
        check("midrst_ram_rd_n", ram_rd_n, 1);
        check("midrst_ram_wr_n", ram_wr_n, 1);
        check("midrst_gnt0", rd_gnt0, 0);
        check("midrst_valid0", rd_valid0, 0);
        rd_req0 = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        tick();
        check("postrst_no_valid", {s_v1, s_v0}, 0);
        check("postrst_ready", s_ready, 1);

        // randomized traffic on a small address pool to provoke hazards
        s_gnt0 = 1'b0; s_gnt1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            wr_req  = ($urandom_range(0, 99) < 40);
            wr_addr = 12'h3F0 + 12'($urandom_range(0, 7));
            wr_data = $urandom;
            if (!rd_req0 || s_gnt0) begin
                rd_req0  = ($urandom_range(0, 99) < 50);
                rd_addr0 = 12'h3F0 + 12'($urandom_range(0, 7));
            end
            if (!rd_req1 || s_gnt1) begin
                rd_req1  = ($urandom_range(0, 99) < 50);
                rd_addr1 = 12'h3F0 + 12'($urandom_range(0, 7));
            end
            tick();
        end
        wr_req = 1'b0; rd_req0 = 1'b0; rd_req1 = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("final_empty", wfifo_empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
